// File: rtl/synth_arith_pkg.sv
// Shared types and default widths for the synth arithmetic blocks
// (ratio divider and sequential multiplier).
package synth_arith_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sequential_multiplier.sv
// Shift-and-add multiplier: scales an unsigned sample by a Q0.FRAC
// fraction, one fraction bit per clock, truncating the result.
module sequential_multiplier
  import synth_arith_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int FRAC  = FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [FRAC-1:0]  fraction,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(FRAC);
  localparam int AW = WIDTH + FRAC + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAC - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [FRAC-1:0]  f_q, f_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] prod_d;
  logic             busy_d;
  logic             done_d;

  logic [WIDTH:0]   acc_hi;
  logic [AW-1:0]    acc_add;
  logic [AW-1:0]    acc_sh;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    f_d     = f_q;
    acc_d   = acc_q;
    prod_d  = product;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    // Upper WIDTH+1 bits keep the carry; after the shift it lands in the MSB.
    acc_hi  = acc_q[AW-1:FRAC] + {1'b0, m_q};
    acc_add = f_q[0] ? {acc_hi, acc_q[FRAC-1:0]} : acc_q;
    acc_sh  = acc_add >> 1;

    unique case (state_q)
      IDLE, DONE: begin
        if (en) begin
          m_d     = multiplicand;
          f_d     = fraction;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d   = acc_sh;
        f_d     = f_q >> 1;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          count_d = '0;
          prod_d  = acc_sh[WIDTH+FRAC-1:FRAC];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      m_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      product <= prod_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed scoreboard bench for sequential_multiplier.
// Expected products come from an integer reference of floor(m*f/256).
module tb_sequential_multiplier;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] multiplicand;
  logic [7:0]  fraction;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int unsigned exp_q[$];
  int vectors;
  int miscompares;

  sequential_multiplier #(.WIDTH(16), .FRAC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .multiplicand (multiplicand),
    .fraction     (fraction),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned ref_mul(int unsigned m, int unsigned f);
    return (m * f) >> 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one start; returns at the first MULT cycle (negedge).
  task automatic start(input int unsigned m, input int unsigned f,
                       input bit push);
    @(negedge clk);
    multiplicand = 16'(m);
    fraction     = 8'(f);
    en           = 1'b1;
    if (push) exp_q.push_back(ref_mul(m, f));
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() > 0) chk(tag, product, exp_q.pop_front());
    else chk({tag, "_sb_empty"}, 32'd1, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    if (done === 1'b1) pop_chk(tag);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst          = 1'b1;
    en           = 1'b0;
    multiplicand = '0;
    fraction     = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_prod", product, 0);
    end

    // 1000 * 0.5, exact latency
    start(1000, 128, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("lat_busy", busy, 1);
      chk("lat_nodone", done, 0);
      @(negedge clk);
    end
    chk("lat_done", done, 1);
    chk("lat_busy_off", busy, 0);
    pop_chk("half");
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("prod_hold", product, 500);

    // Boundaries and truncation
    start(16'hFFFF, 8'hFF, 1'b1);
    wait_done("max", 20);
    start(12345, 1, 1'b1);
    wait_done("trunc", 20);
    start(54321, 0, 1'b1);
    wait_done("zero_frac", 20);

    // Back-to-back with en held high
    @(negedge clk);
    multiplicand = 16'd200;
    fraction     = 8'd64;
    en           = 1'b1;
    exp_q.push_back(ref_mul(200, 64));
    @(negedge clk);
    multiplicand = 16'd300;
    fraction     = 8'd255;
    exp_q.push_back(ref_mul(300, 255));
    wait_done("b2b_first", 20);
    n = 0;
    do begin
      @(negedge clk);
      en = ~en;
      n++;
    end while (done !== 1'b1 && n < 20);
    en = 1'b0;
    chk("b2b_gap", n, 9);
    chk("b2b_second_done", done, 1);
    if (done === 1'b1) pop_chk("b2b_second");
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);

    // Reset mid-operation discards the result
    start(4000, 200, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_prod", product, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("mid_no_done", n, 0);
    start(4000, 200, 1'b1);
    wait_done("restart", 20);

    // Operand changes after capture are ignored
    start(777, 99, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      multiplicand = 16'($urandom);
      fraction     = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk("scramble_done", done, 1);
    if (done === 1'b1) pop_chk("scramble");

    repeat (3) @(negedge clk);
    chk("final_hold", product, ref_mul(777, 99));
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
